sprite_blitter: RTL and testbench

// - Copies one palette-indexed sprite from a sprite ROM into the frame buffer at a requested screen position.
// - Drives the ROM read address, consumes the ROM's 5-bit pixel one clock later, drops transparent and off-screen pixels, and issues write requests to the frame buffer.
// - Sits between game logic (Start/Pos) and the sprite ROM / frame-buffer write port.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_blitter_if.sv | 39 +++
 rtl/pix_skid_buf.sv | 60 ++++++
 rtl/sprite_blitter.sv | 176 +++++++++++++++++
 tb/tb_sprite_blitter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and pixel-entry type for the sprite blitter.
package sprite_pkg;

  localparam int FB_WIDTH   = 640;
  localparam int FB_HEIGHT  = 480;
  localparam int FB_ADDR_W  = 19;
  localparam int PIX_W      = 5;
  localparam int ROM_ADDR_W = 15;
  localparam int POS_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } blit_state_e;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]     data;
  } pix_entry_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Control, sprite-ROM and frame-buffer signals of the sprite blitter.
// Optional HFLIP_EN adds the Flip request bit.
interface sprite_blitter_if;
  import sprite_pkg::*;

  logic                  Start;
  logic [POS_W-1:0]      Pos_X;
  logic [POS_W-1:0]      Pos_Y;
  logic                  Busy;
  logic                  Done;
  logic [ROM_ADDR_W-1:0] Rom_Addr;
  logic [PIX_W-1:0]      Rom_Data;
  logic [FB_ADDR_W-1:0]  Fb_Addr;
  logic [PIX_W-1:0]      Fb_Data;
  logic                  Fb_We;
  logic                  Fb_Ready;
`ifdef HFLIP_EN
  logic                  Flip;
`endif

  // Blitter side
  modport slave (
`ifdef HFLIP_EN
    input  Flip,
`endif
    input  Start, Pos_X, Pos_Y, Rom_Data, Fb_Ready,
    output Busy, Done, Rom_Addr, Fb_Addr, Fb_Data, Fb_We
  );

  // Game logic / ROM / frame-buffer side
  modport master (
`ifdef HFLIP_EN
    output Flip,
`endif
    output Start, Pos_X, Pos_Y, Rom_Data, Fb_Ready,
    input  Busy, Done, Rom_Addr, Fb_Addr, Fb_Data, Fb_We
  );

endinterface

// File: rtl/pix_skid_buf.sv
// Two-entry FIFO holding pixels waiting for the frame-buffer write port.
module pix_skid_buf
  import sprite_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       push,
  input  pix_entry_t push_entry,
  input  logic       pop,
  output pix_entry_t head,
  output logic [1:0] occupancy,
  output logic       full,
  output logic       empty
);

  pix_entry_t mem_q [2];
  pix_entry_t mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign occupancy = cnt_q;
  assign head      = mem_q[rd_ptr_q];

  // Next-state of storage, pointers and count for push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = !rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Storage and pointer registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks the sprite ROM row-major, drops transparent and
// off-screen pixels and writes the rest into the frame buffer in raster order.
// Optional macro HFLIP_EN mirrors ROM addressing horizontally when Flip=1.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W  = 150,
  parameter int SPR_H  = 120,
  parameter int FB_W   = FB_WIDTH,
  parameter int FB_H   = FB_HEIGHT,
  parameter int TRANSP = 0
) (
  input logic             Clk,
  input logic             Reset_n,
  sprite_blitter_if.slave bus
);

  localparam logic [POS_W-1:0]      COL_LAST   = POS_W'(SPR_W - 1);
  localparam logic [POS_W-1:0]      ROW_LAST   = POS_W'(SPR_H - 1);
  localparam logic [ROM_ADDR_W-1:0] ROW_STRIDE = ROM_ADDR_W'(SPR_W);
  localparam logic [POS_W:0]        FB_W_LIM   = (POS_W + 1)'(FB_W);
  localparam logic [POS_W:0]        FB_H_LIM   = (POS_W + 1)'(FB_H);
  localparam logic [PIX_W-1:0]      TRANSP_PIX = PIX_W'(TRANSP);

  blit_state_e           state_q, state_d;
  logic [POS_W-1:0]      pos_x_q, pos_x_d;
  logic [POS_W-1:0]      pos_y_q, pos_y_d;
  logic [POS_W-1:0]      col_q, col_d;
  logic [POS_W-1:0]      row_q, row_d;
  logic [ROM_ADDR_W-1:0] row_base_q, row_base_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [POS_W:0]        x_p1_q, x_p1_d;
  logic [POS_W:0]        y_p1_q, y_p1_d;
  logic [POS_W-1:0]      col_off;
`ifdef HFLIP_EN
  logic                  flip_q, flip_d;
`endif

  logic       issue;
  logic       keep;
  logic       buf_push, buf_pop;
  logic       buf_full, buf_empty;
  logic [1:0] buf_occ;
  pix_entry_t buf_head, new_entry;

  // Column offset into the ROM row, mirrored when a flipped blit is active
`ifdef HFLIP_EN
  assign col_off = flip_q ? (COL_LAST - col_q) : col_q;
`else
  assign col_off = col_q;
`endif

  // Stage p0: ROM address issue; ROM answers one clock later
  assign bus.Rom_Addr = row_base_q + ROM_ADDR_W'(col_off);

  // Stage p1: ROM pixel and its screen position meet; decide keep/drop
  assign keep = vld_p1_q && (bus.Rom_Data != TRANSP_PIX) &&
                (x_p1_q < FB_W_LIM) && (y_p1_q < FB_H_LIM);
  assign new_entry.fb_addr = FB_ADDR_W'(32'(y_p1_q) * 32'(FB_W) + 32'(x_p1_q));
  assign new_entry.data    = bus.Rom_Data;
  assign buf_push = keep && !buf_full;

  // Stage p2: buffer head drives the frame-buffer write port
  assign buf_pop     = !buf_empty && bus.Fb_Ready;
  assign bus.Fb_We   = !buf_empty;
  assign bus.Fb_Addr = buf_head.fb_addr;
  assign bus.Fb_Data = buf_head.data;

  assign bus.Busy = (state_q != ST_IDLE);
  assign bus.Done = (state_q == ST_FIN);

  // An address may issue only if the buffer can still absorb every pixel
  // already committed, even if the write port stalls from now on.
  assign issue = (state_q == ST_RUN) &&
                 (({1'b0, buf_occ} + {2'b00, vld_p1_q} - {2'b00, buf_pop}) <= 3'd1);

  // FSM next state, position capture and raster counters
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    vld_p1_d   = issue;
    x_p1_d     = x_p1_q;
    y_p1_d     = y_p1_q;
`ifdef HFLIP_EN
    flip_d     = flip_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d = ST_RUN;
          pos_x_d = bus.Pos_X;
          pos_y_d = bus.Pos_Y;
`ifdef HFLIP_EN
          flip_d  = bus.Flip;
`endif
        end
      end
      ST_RUN: begin
        if (issue) begin
          x_p1_d = {1'b0, pos_x_q} + {1'b0, col_q};
          y_p1_d = {1'b0, pos_y_q} + {1'b0, row_q};
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d      = '0;
              row_base_d = '0;
              state_d    = ST_DRAIN;
            end else begin
              row_d      = row_q + 1'b1;
              row_base_d = row_base_q + ROW_STRIDE;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!vld_p1_q && buf_empty) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control, counter and pipeline registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      vld_p1_q   <= 1'b0;
      x_p1_q     <= '0;
      y_p1_q     <= '0;
`ifdef HFLIP_EN
      flip_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      vld_p1_q   <= vld_p1_d;
      x_p1_q     <= x_p1_d;
      y_p1_q     <= y_p1_d;
`ifdef HFLIP_EN
      flip_q     <= flip_d;
`endif
    end
  end

  pix_skid_buf u_skid (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .push       (buf_push),
    .push_entry (new_entry),
    .pop        (buf_pop),
    .head       (buf_head),
    .occupancy  (buf_occ),
    .full       (buf_full),
    .empty      (buf_empty)
  );

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter with a 4x3 sprite and 1-cycle ROM model.
module tb_sprite_blitter;

  localparam int SPR_W = 4;
  localparam int SPR_H = 3;
  localparam int FB_W  = 640;
  localparam int FB_H  = 480;
  localparam int NPIX  = 12;

  typedef struct {
    int a;
    int d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rand_ready = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;
  int   last_acc = 0;
  int   done_base, acc_base, acc_mark, c2;
  exp_t exp_q[$];
  logic [4:0] rom [NPIX];

  sprite_blitter_if bus();

  sprite_blitter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .TRANSP(0)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM with one clock of read latency
  always @(posedge clk)
    bus.Rom_Data <= (bus.Rom_Addr < 15'(NPIX)) ? rom[bus.Rom_Addr[3:0]] : 5'd0;

  // Write-port ready: constant 1 or a coin toss per cycle
  initial begin
    bus.Fb_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.Fb_Ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write
  initial begin
    logic       stall_prev;
    int         hold_addr, hold_data;
    exp_t       e;
    stall_prev = 1'b0;
    hold_addr  = 0;
    hold_data  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_we_hold", int'(bus.Fb_We), 1);
          check("stall_addr_hold", int'(bus.Fb_Addr), hold_addr);
          check("stall_data_hold", int'(bus.Fb_Data), hold_data);
        end
        if (bus.Fb_We && bus.Fb_Ready) begin
          acc_cnt++;
          last_acc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                     bus.Fb_Addr, bus.Fb_Data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", int'(bus.Fb_Addr), e.a);
            check("wr_data", int'(bus.Fb_Data), e.d);
          end
        end
        if (bus.Done) done_cnt++;
        stall_prev = bus.Fb_We && !bus.Fb_Ready;
        hold_addr  = int'(bus.Fb_Addr);
        hold_data  = int'(bus.Fb_Data);
      end
    end
  end

  task automatic expect_wr(input int a, input int d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic load_rom_seq();
    for (int i = 0; i < NPIX; i++) rom[i] = 5'(i + 1);
  endtask

  task automatic start_blit(input int x, input int y);
    done_base = done_cnt;
    acc_base  = acc_cnt;
    @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.Pos_X = 10'(x);
    bus.Pos_Y = 10'(y);
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic finish_blit(input string name, input int nwr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.Done) seen = 1'b1;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_busy_low"}, int'(bus.Busy), 0);
    check({name, "_done_count"}, done_cnt - done_base, 1);
    check({name, "_write_count"}, acc_cnt - acc_base, nwr);
    check({name, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  // Expected screen addresses of a 4x3 sprite placed at (0,0)
  int t1_addr [NPIX] = '{0, 1, 2, 3, 640, 641, 642, 643, 1280, 1281, 1282, 1283};

  initial begin
    bus.Start = 1'b0;
    bus.Pos_X = '0;
    bus.Pos_Y = '0;
`ifdef HFLIP_EN
    bus.Flip  = 1'b0;
`endif
    load_rom_seq();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.Busy), 0);
    check("rst_done", int'(bus.Done), 0);
    check("rst_fb_we", int'(bus.Fb_We), 0);
    check("rst_rom_addr", int'(bus.Rom_Addr), 0);
    check("rst_fb_addr", int'(bus.Fb_Addr), 0);
    check("rst_fb_data", int'(bus.Fb_Data), 0);
    rst_n = 1'b1;

    // Opaque sprite at origin, ready always high
    for (int i = 0; i < NPIX; i++) expect_wr(t1_addr[i], i + 1);
    start_blit(0, 0);
    check("t1_busy_after_start", int'(bus.Busy), 1);
    check("t1_we_cycle1", int'(bus.Fb_We), 0);
    @(posedge clk);
    #1;
    check("t1_we_cycle2", int'(bus.Fb_We), 0);
    @(posedge clk);
    #1;
    c2 = cyc;
    check("t1_we_cycle3", int'(bus.Fb_We), 1);
    check("t1_first_addr", int'(bus.Fb_Addr), 0);
    check("t1_first_data", int'(bus.Fb_Data), 1);
    finish_blit("t1", 12);
    check("t1_one_per_clk", last_acc - c2, 11);

    // ROM words 2 and 7 transparent: screen addresses 2 and 643 skipped
    rom[2] = 5'd0;
    rom[7] = 5'd0;
    for (int i = 0; i < NPIX; i++)
      if (i != 2 && i != 7) expect_wr(t1_addr[i], i + 1);
    start_blit(0, 0);
    finish_blit("t2", 10);
    load_rom_seq();

    // Random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) expect_wr(t1_addr[i], i + 1);
    start_blit(0, 0);
    finish_blit("t3", 12);
    rand_ready = 1'b0;

    // Bottom-right corner: only the 2x2 top-left block is on screen
    expect_wr(306558, 1);
    expect_wr(306559, 2);
    expect_wr(307198, 5);
    expect_wr(307199, 6);
    start_blit(638, 478);
    finish_blit("t4", 4);

    // Fully off-screen
    start_blit(640, 0);
    finish_blit("t5", 0);

    // Fully transparent sprite
    for (int i = 0; i < NPIX; i++) rom[i] = 5'd0;
    start_blit(0, 0);
    finish_blit("t6", 0);
    load_rom_seq();

    // Start while busy is ignored
    for (int i = 0; i < NPIX; i++) expect_wr(t1_addr[i], i + 1);
    start_blit(0, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.Pos_X = 10'd100;
    bus.Pos_Y = 10'd100;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    finish_blit("t7", 12);

    // Reset in the middle of a blit
    for (int i = 0; i < NPIX; i++) expect_wr(t1_addr[i], i + 1);
    start_blit(0, 0);
    for (int i = 0; i < 100 && (acc_cnt - acc_base) < 4; i++) @(posedge clk);
    #1;
    check("t8_writes_before_reset", int'((acc_cnt - acc_base) >= 4), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t8_we_after_reset", int'(bus.Fb_We), 0);
    check("t8_busy_after_reset", int'(bus.Busy), 0);
    rst_n = 1'b1;
    exp_q.delete();
    acc_mark  = acc_cnt;
    done_base = done_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("t8_no_writes_after_reset", acc_cnt - acc_mark, 0);
    check("t8_no_done_after_reset", done_cnt - done_base, 0);

`ifdef HFLIP_EN
    // Mirrored blit: screen column c shows ROM column 3-c
    bus.Flip = 1'b1;
    for (int r = 0; r < SPR_H; r++)
      for (int c = 0; c < SPR_W; c++)
        expect_wr(r * FB_W + c, r * SPR_W + (SPR_W - c));
    start_blit(0, 0);
    bus.Flip = 1'b0;
    finish_blit("t9", 12);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the run ever stalls
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
